mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit for the KGPminiRISC core. It replaces the single-cycle combinational opcode decoder.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, holding on instruction/data memory handshakes.
//  Emits the same datapath strobes as the single-cycle decoder, qualified per state, plus a latched illegal-op/timeout halt.
//  Sits between the instruction register and the datapath muxes, PC, register file and memories.
// PARAMETERS
//  OPW         6   opcode width; legal opcodes are 0..11, all others are illegal
//  ALUOPW      4   ALUop output width (>=4)
//  MEM_TIMEOUT 15  max wait cycles for imem_ready/dmem_ready before HALT (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  run          in   1       IDLE->FETCH enable
//  opcode       in   OPW     IR opcode field; sampled in DECODE
//  imem_ready   in   1       instruction memory accepted/returned word
//  dmem_ready   in   1       data memory completed access
//  imem_req     out  1       instruction fetch request
//  ir_write     out  1       load IR
//  pc_write     out  1       PC <= PC+4
//  RegWrite     out  1       register file write enable
//  RegDst       out  2       00 rt, 01 rd, 10 r31
//  MemRead      out  1       data memory read request
//  MemWrite     out  1       data memory write request
//  MemToReg     out  2       00 ALU, 01 memory, 10 PC+4
//  ALUop        out  ALUOPW  ALU operation select
//  CondJump     out  1       branch-if-zero strobe; datapath qualifies it with the zero flag
//  UncondJump   out  1       jump strobe
//  busy         out  1       state != IDLE && state != HALT
//  halted       out  1       in HALT
//  err_code     out  2       00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT (3-bit register).
//  Outputs are Moore outputs, decoded from state and op_q (opcode registered in DECODE).
//  rst: state=IDLE, op_q=0, wait counter=0, err_code=00. Every output is 0 in IDLE.
//  Opcode classes and ALUop:
//   - 0..7 ALU: ALUop=op_q zero-extended. 0..5 use RegDst=01; 6..7 (immediate) use RegDst=00.
//   - 8 LD and 9 ST: ALUop=0 (add).
//   - 10 BZ: ALUop=1 (sub).
//   - 11 JAL: ALUop=0.
//  Transitions:
//   - IDLE: ->FETCH when run=1.
//   - FETCH: assert imem_req. When imem_ready=1, pulse ir_write and pc_write that cycle, then ->DECODE.
//   - DECODE: latch opcode into op_q. Illegal opcode (>11): ->HALT with err=01. Otherwise ->EXEC.
//   - EXEC: drive ALUop.
//     - BZ: CondJump=1, ->FETCH.
//     - JAL: UncondJump=1, ->WB.
//     - LD/ST: ->MEM.
//     - ALU ops: ->WB.
//   - MEM: LD holds MemRead=1, ST holds MemWrite=1, held until dmem_ready=1 (inclusive).
//     - On dmem_ready: LD ->WB, ST ->FETCH.
//   - WB: RegWrite=1 for exactly one cycle, ->FETCH.
//     - RegDst/MemToReg: ALU 01|00/00, LD 00/01, JAL 10/10.
//  Latency with ready=1 on first request: ALU 4, LD 5, ST 4, BZ 3, JAL 4 cycles.
//  Wait counter:
//   - Cleared on entering FETCH or MEM; increments each cycle ready=0 in those states.
//   - If ready=0 when counter==MEM_TIMEOUT: ->HALT, err=10 (FETCH) or 11 (MEM).
//   - ready=1 on the limit cycle wins over timeout.
//  HALT: all strobes 0, halted=1. Leaves only on rst. run is ignored.
//  run deasserted mid-instruction has no effect; it is checked only in IDLE.
//  rst mid-instruction: next cycle state=IDLE and all strobes 0. No pending write completes.
//  Never assert RegWrite, MemRead and MemWrite together; never assert pc_write outside FETCH.
// TESTING
//  1) rst, run=1, opcode=2, both readys=1:
//     IDLE,FETCH,DECODE,EXEC,WB,FETCH.
//     ALUop=2 in EXEC; RegWrite=1 and RegDst=01 only in WB.
//  2) opcode=8 (LD), dmem_ready low 3 cycles:
//     MemRead high 4 cycles; then WB with MemToReg=01, RegDst=00.
//     Total latency 8 cycles.
//  3) opcode=10: CondJump=1 exactly in EXEC, ALUop=1, back to FETCH.
//     opcode=11: UncondJump in EXEC, then WB with RegDst=10, MemToReg=10.
//  4) opcode=13: HALT after DECODE, err_code=01, halted=1.
//     run toggling is ignored; rst returns to IDLE with err_code=00.
//  5) imem_ready held 0: HALT after MEM_TIMEOUT+1 FETCH cycles, err_code=10.
//     Repeat with ready=1 on the limit cycle -> no halt.
//  6) assert rst during MEM of ST (MemWrite=1): next cycle state=IDLE and MemWrite=0.
//     No WB or FETCH occurs until run.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control unit for the KGPminiRISC core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on the
// instruction and data memory handshakes. Datapath strobes are decoded from
// the current state and the opcode latched in DECODE. An illegal opcode or a
// memory timeout sends the unit to HALT, which only rst can clear.
//
// Handshake semantics: imem_req (FETCH) and MemRead/MemWrite (MEM) are held
// high for as long as the unit sits in that state. A cycle in which the
// matching ready input is high completes the transfer, and the unit leaves
// the state on the next edge. A request is never withdrawn before ready
// arrives, except when the wait limit is reached or rst is asserted.
module mc_ctrl_fsm #(
    parameter int OPW         = 6,
    parameter int ALUOPW      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [OPW-1:0]    opcode,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              imem_req,
    output logic              ir_write,
    output logic              pc_write,
    output logic              RegWrite,
    output logic [1:0]        RegDst,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [1:0]        MemToReg,
    output logic [ALUOPW-1:0] ALUop,
    output logic              CondJump,
    output logic              UncondJump,
    output logic              busy,
    output logic              halted,
    output logic [1:0]        err_code,
    output logic [2:0]        dbgState
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [OPW-1:0] OP_ALU_LAST = OPW'(7);
    localparam logic [OPW-1:0] OP_REG_LAST = OPW'(5);
    localparam logic [OPW-1:0] OP_LD       = OPW'(8);
    localparam logic [OPW-1:0] OP_ST       = OPW'(9);
    localparam logic [OPW-1:0] OP_BZ       = OPW'(10);
    localparam logic [OPW-1:0] OP_JAL      = OPW'(11);

    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_TIMEOUT);

    logic [2:0]     state;
    logic [2:0]     nextState;
    logic [OPW-1:0] opQ;
    logic [CW-1:0]  waitCnt;
    logic [1:0]     errQ;

    logic illegalOp;
    logic fetchTimeout;
    logic memTimeout;

    assign illegalOp    = (opcode > OP_JAL);
    assign fetchTimeout = (state == ST_FETCH) && !imem_ready && (waitCnt == WAIT_LIMIT);
    assign memTimeout   = (state == ST_MEM) && !dmem_ready && (waitCnt == WAIT_LIMIT);

    // Next-state selection; ready on the limit cycle wins over the timeout.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (run) nextState = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready)        nextState = ST_DECODE;
                else if (fetchTimeout) nextState = ST_HALT;
            end
            ST_DECODE: begin
                nextState = illegalOp ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (opQ == OP_BZ)                        nextState = ST_FETCH;
                else if (opQ == OP_LD || opQ == OP_ST)   nextState = ST_MEM;
                else                                     nextState = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ready)      nextState = (opQ == OP_LD) ? ST_WB : ST_FETCH;
                else if (memTimeout) nextState = ST_HALT;
            end
            ST_WB: begin
                nextState = ST_FETCH;
            end
            ST_HALT: begin
                nextState = ST_HALT;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // State, latched opcode, wait counter and sticky error code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            opQ     <= '0;
            waitCnt <= '0;
            errQ    <= 2'b00;
        end else begin
            state <= nextState;
            if (state == ST_DECODE) opQ <= opcode;
            // Any state change clears the counter, so it starts at zero on
            // every entry into FETCH or MEM.
            if (nextState != state) begin
                waitCnt <= '0;
            end else if ((state == ST_FETCH && !imem_ready) ||
                         (state == ST_MEM && !dmem_ready)) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (state == ST_DECODE && illegalOp) errQ <= 2'b01;
            else if (fetchTimeout)               errQ <= 2'b10;
            else if (memTimeout)                 errQ <= 2'b11;
        end
    end

    // Datapath strobes qualified by the current state.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemToReg   = 2'b00;
        ALUop      = '0;
        CondJump   = 1'b0;
        UncondJump = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            ST_EXEC: begin
                if (opQ <= OP_ALU_LAST) ALUop = ALUOPW'(opQ);
                else if (opQ == OP_BZ)  ALUop = ALUOPW'(1);
                else                    ALUop = '0;
                CondJump   = (opQ == OP_BZ);
                UncondJump = (opQ == OP_JAL);
            end
            ST_MEM: begin
                MemRead  = (opQ == OP_LD);
                MemWrite = (opQ == OP_ST);
            end
            ST_WB: begin
                RegWrite = 1'b1;
                if (opQ == OP_JAL) begin
                    RegDst   = 2'b10;
                    MemToReg = 2'b10;
                end else if (opQ == OP_LD) begin
                    RegDst   = 2'b00;
                    MemToReg = 2'b01;
                end else begin
                    RegDst   = (opQ <= OP_REG_LAST) ? 2'b01 : 2'b00;
                    MemToReg = 2'b00;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy     = (state != ST_IDLE) && (state != ST_HALT);
    assign halted   = (state == ST_HALT);
    assign err_code = errQ;
    assign dbgState = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: each instruction is expanded into its expected
// per-cycle phase sequence (inputs to drive plus outputs to expect) from the
// instruction class and the chosen memory wait counts, then played cycle by
// cycle against the DUT.
module tb_mc_ctrl_fsm;

    localparam int OPW    = 6;
    localparam int ALUOPW = 4;
    localparam int TO     = 15;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [OPW-1:0]    opcode;
    logic              imemReady;
    logic              dmemReady;
    logic              imemReq;
    logic              irWrite;
    logic              pcWrite;
    logic              regWrite;
    logic [1:0]        regDst;
    logic              memRead;
    logic              memWrite;
    logic [1:0]        memToReg;
    logic [ALUOPW-1:0] aluOp;
    logic              condJump;
    logic              uncondJump;
    logic              busy;
    logic              halted;
    logic [1:0]        errCode;
    logic [2:0]        dbgState;

    mc_ctrl_fsm #(.OPW(OPW), .ALUOPW(ALUOPW), .MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .imem_ready (imemReady),
        .dmem_ready (dmemReady),
        .imem_req   (imemReq),
        .ir_write   (irWrite),
        .pc_write   (pcWrite),
        .RegWrite   (regWrite),
        .RegDst     (regDst),
        .MemRead    (memRead),
        .MemWrite   (memWrite),
        .MemToReg   (memToReg),
        .ALUop      (aluOp),
        .CondJump   (condJump),
        .UncondJump (uncondJump),
        .busy       (busy),
        .halted     (halted),
        .err_code   (errCode),
        .dbgState   (dbgState)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        st;
        logic              imemReq;
        logic              irWrite;
        logic              pcWrite;
        logic              regWrite;
        logic [1:0]        regDst;
        logic              memRead;
        logic              memWrite;
        logic [1:0]        memToReg;
        logic [ALUOPW-1:0] aluOp;
        logic              condJump;
        logic              uncondJump;
        logic              busy;
        logic              halted;
        logic [1:0]        errCode;
    } obs_t;

    typedef struct {
        string          tag;
        logic           runV;
        logic           imr;
        logic           dmr;
        logic [OPW-1:0] opc;
        obs_t           exp;
    } cyc_t;

    cyc_t       cycQ[$];
    int         checkCnt = 0;
    int         passCnt  = 0;
    logic [1:0] mErr = 2'b00;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [OPW-1:0] randOp();
        return OPW'($urandom_range(0, (1 << OPW) - 1));
    endfunction

    function automatic obs_t baseObs(input logic [2:0] st);
        obs_t o;
        o         = '0;
        o.st      = st;
        o.busy    = (st != S_IDLE) && (st != S_HALT);
        o.halted  = (st == S_HALT);
        o.errCode = mErr;
        return o;
    endfunction

    task automatic push(input string tag, input logic r, input logic imr,
                        input logic dmr, input logic [OPW-1:0] opc, input obs_t o);
        cyc_t c;
        c.tag  = tag;
        c.runV = r;
        c.imr  = imr;
        c.dmr  = dmr;
        c.opc  = opc;
        c.exp  = o;
        cycQ.push_back(c);
    endtask

    task automatic addIdle(input int n);
        for (int i = 0; i < n; i++) push("idle", 1'b0, rb(), rb(), randOp(), baseObs(S_IDLE));
    endtask

    task automatic addStart();
        push("idle_run", 1'b1, rb(), rb(), randOp(), baseObs(S_IDLE));
    endtask

    task automatic addHalt(input int n);
        for (int i = 0; i < n; i++) push("halt", rb(), rb(), rb(), randOp(), baseObs(S_HALT));
    endtask

    // One instruction: fw / mw are the number of not-ready cycles before the
    // instruction / data memory answers; a value above TO means it never does.
    task automatic addInstr(input int op, input int fw, input int mw);
        obs_t o;
        int   n;
        n = (fw > TO) ? TO + 1 : fw;
        for (int i = 0; i < n; i++) begin
            o = baseObs(S_FETCH);
            o.imemReq = 1'b1;
            push("fetch_wait", rb(), 1'b0, rb(), randOp(), o);
        end
        if (fw > TO) begin
            mErr = 2'b10;
            return;
        end
        o = baseObs(S_FETCH);
        o.imemReq = 1'b1;
        o.irWrite = 1'b1;
        o.pcWrite = 1'b1;
        push("fetch", rb(), 1'b1, rb(), randOp(), o);

        push("decode", rb(), rb(), rb(), OPW'(op), baseObs(S_DECODE));
        if (op > 11) begin
            mErr = 2'b01;
            return;
        end

        o = baseObs(S_EXEC);
        if (op <= 7)       o.aluOp = ALUOPW'(op);
        else if (op == 10) o.aluOp = ALUOPW'(1);
        else               o.aluOp = '0;
        o.condJump   = (op == 10);
        o.uncondJump = (op == 11);
        push("exec", rb(), rb(), rb(), randOp(), o);

        if (op == 8 || op == 9) begin
            n = (mw > TO) ? TO + 1 : mw;
            for (int i = 0; i < n; i++) begin
                o = baseObs(S_MEM);
                o.memRead  = (op == 8);
                o.memWrite = (op == 9);
                push("mem_wait", rb(), rb(), 1'b0, randOp(), o);
            end
            if (mw > TO) begin
                mErr = 2'b11;
                return;
            end
            o = baseObs(S_MEM);
            o.memRead  = (op == 8);
            o.memWrite = (op == 9);
            push("mem", rb(), rb(), 1'b1, randOp(), o);
        end

        if (op <= 8 || op == 11) begin
            o = baseObs(S_WB);
            o.regWrite = 1'b1;
            if (op == 11) begin
                o.regDst   = 2'b10;
                o.memToReg = 2'b10;
            end else if (op == 8) begin
                o.regDst   = 2'b00;
                o.memToReg = 2'b01;
            end else begin
                o.regDst   = (op <= 5) ? 2'b01 : 2'b00;
                o.memToReg = 2'b00;
            end
            push("wb", rb(), rb(), rb(), randOp(), o);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, check at the falling edge.
    task automatic stepOne(input cyc_t c);
        obs_t got;
        run       = c.runV;
        imemReady = c.imr;
        dmemReady = c.dmr;
        opcode    = c.opc;
        @(negedge clk);
        got.st         = dbgState;
        got.imemReq    = imemReq;
        got.irWrite    = irWrite;
        got.pcWrite    = pcWrite;
        got.regWrite   = regWrite;
        got.regDst     = regDst;
        got.memRead    = memRead;
        got.memWrite   = memWrite;
        got.memToReg   = memToReg;
        got.aluOp      = aluOp;
        got.condJump   = condJump;
        got.uncondJump = uncondJump;
        got.busy       = busy;
        got.halted     = halted;
        got.errCode    = errCode;
        checkCnt++;
        assert (got === c.exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", c.tag, got, c.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic runQ(input int n);
        cyc_t c;
        for (int i = 0; i < n && cycQ.size() > 0; i++) begin
            c = cycQ.pop_front();
            stepOne(c);
        end
    endtask

    task automatic runAll();
        runQ(cycQ.size());
    endtask

    task automatic doReset();
        rst       = 1'b1;
        run       = rb();
        imemReady = rb();
        dmemReady = rb();
        opcode    = randOp();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mErr = 2'b00;
        cycQ.delete();
    endtask

    initial begin
        cyc_t c;
        int   op;
        int   fw;
        int   mw;

        rst       = 1'b1;
        run       = 1'b0;
        imemReady = 1'b0;
        dmemReady = 1'b0;
        opcode    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, then directed ALU / LD with data waits / BZ / JAL / ST.
        addIdle(2);
        addStart();
        addInstr(2, 0, 0);
        addInstr(8, 0, 3);
        addInstr(10, 0, 0);
        addInstr(11, 0, 0);
        addInstr(9, 0, 0);
        addInstr(6, 1, 0);
        runAll();

        // Random legal instruction stream with random handshake delays.
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 11);
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, TO) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, TO) : $urandom_range(0, 2);
            addInstr(op, fw, mw);
            runAll();
        end

        // Illegal opcode halts; run toggling ignored; reset clears the error.
        doReset();
        addStart();
        addInstr(13, 1, 0);
        addHalt(8);
        runAll();
        doReset();
        addIdle(3);
        addStart();
        addInstr($urandom_range(12, (1 << OPW) - 1), 0, 0);
        addHalt(3);
        runAll();

        // Instruction memory never answers: halt after TO+1 fetch cycles.
        doReset();
        addStart();
        addInstr(2, TO + 1, 0);
        addHalt(5);
        runAll();

        // Ready on the limit cycle wins; then a data memory timeout.
        doReset();
        addIdle(1);
        addStart();
        addInstr(4, TO, 0);
        addInstr(9, 0, TO);
        addInstr(8, 0, TO + 1);
        addHalt(4);
        runAll();

        // Reset in the middle of a store's MEM wait: nothing further happens until run.
        doReset();
        addStart();
        addInstr(9, 0, TO + 1);
        runQ(6);
        c   = cycQ.pop_front();
        rst = 1'b1;
        stepOne(c);
        rst = 1'b0;
        cycQ.delete();
        mErr = 2'b00;
        addIdle(5);
        addStart();
        addInstr(0, 0, 0);
        runAll();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
